imem_access_arbiter: RTL and testbench
======================================

Name: imem_access_arbiter

Overview:
- Shares a single-port, synchronous-read instruction memory between two requesters:
  - the core's instruction-fetch stage;
  - a loader/debug port that writes and reads program words, e.g. from a UART boot loader.
- Translates byte addresses in the text segment to word indices.
- Arbitrates round-robin and routes each 1-cycle-latency read response back to the requester that issued it.
- Sits between the fetch stage / loader and the program memory array in the single-cycle/multicycle RISC-V top level.

Parameters:
- DATA_WIDTH, 32, width of instruction/data words and byte addresses.
- MEMORY_DEPTH, 128, number of words in the memory array.
- ADDR_WIDTH, 7, word-index width; must equal ceil(log2(MEMORY_DEPTH)).
- TEXT_BASE, 32'h0040_0000, byte address mapped to word 0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  reset is synchronous and active-low.
- if_req  in  1  fetch request; held until granted.
- if_addr  in  DATA_WIDTH  fetch byte address (PC).
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch response valid (one-cycle pulse).
- if_rdata  out  DATA_WIDTH  fetched instruction.
- if_err  out  1  fetch address fault, qualified by if_rvalid.
- ld_req  in  1  loader request; held until granted.
- ld_we  in  1  1 = write, 0 = read.
- ld_addr  in  DATA_WIDTH  loader byte address.
- ld_wdata  in  DATA_WIDTH  loader write data.
- ld_gnt  out  1  loader request accepted this cycle.
- ld_rvalid  out  1  loader response valid (pulse; also issued for writes as an ack).
- ld_rdata  out  DATA_WIDTH  loader read data (0 for writes).
- ld_err  out  1  loader address fault, qualified by ld_rvalid.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory word index.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_en with mem_we=0.

Behaviour:
- Reset (reset==0 at clk edge):
  - all outputs 0;
  - in-flight response discarded (no rvalid after reset);
  - round-robin pointer set to favour fetch;
  - with the optional feature enabled, the FSM goes to BOOT.
- Grant logic is combinational from the requests and registered state:
  - at most one grant per cycle;
  - mem_en/mem_we/mem_addr/mem_wdata are driven in the same cycle as the grant.
- Arbitration:
  - only one requester active: it is granted.
  - both active: grant the requester not granted last; pointer updates only on a grant.
  - A requester waits at most 1 cycle under continuous contention.
- Address check, per request (addr = byte address):
  - off = addr - TEXT_BASE;
  - fault if addr < TEXT_BASE, off[1:0] != 0, or off[DATA_WIDTH-1:2] >= MEMORY_DEPTH;
  - otherwise mem_addr = off[ADDR_WIDTH+1:2].
- Faulted request:
  - still granted, but mem_en = 0;
  - next cycle the owner's rvalid = 1, err = 1, rdata = 0.
- Fetch requests never write; mem_we = ld_gnt & ld_we & ~fault.
- Response pipeline: 1-entry register {valid, owner, err, is_write}, loaded on every grant.
  - The next cycle, the owner's rvalid pulses.
  - rdata = mem_rdata for a good read, 0 otherwise.
  - The other port's rvalid = 0 and its rdata holds 0.
- Throughput: back-to-back grants every cycle; latency grant → rvalid = 1 cycle.
- Simultaneous loader write and fetch to the same word:
  - arbitration orders them;
  - a later read observes an earlier write (memory is write-first across cycles).
- Requests deasserted before grant are dropped silently; address/data need only be stable in the grant cycle.
- Reset asserted mid-transaction: the response is lost; requesters reissue.

Optional Feature:
- Macro: IMEM_BOOT_HOLD_EN.
- Defined:
  - adds input port ld_done (1 bit) and a 2-state FSM, BOOT → RUN.
  - BOOT: if_req is never granted; loader arbitrates alone.
  - BOOT → RUN on the first cycle ld_done==1 with no loader grant that cycle; RUN is held until reset.
  - RUN: normal round-robin.
  - Use: the CPU is stalled until the program is loaded.
- Undefined: no ld_done port, no FSM; the block behaves as RUN from reset.

Test Plan:
- Reset then if_req=1, if_addr=0x0040_0008, mem preloaded word2=0x00500293:
  - if_gnt=1, mem_en=1, mem_addr=2 in that cycle;
  - next cycle if_rvalid=1, if_rdata=0x00500293, if_err=0.
- ld_req=1, ld_we=1, ld_addr=0x0040_0010, ld_wdata=0xDEADBEEF:
  - ld_gnt=1, mem_we=1, mem_addr=4;
  - next cycle ld_rvalid=1, ld_rdata=0, ld_err=0.
  - Follow-up fetch of 0x0040_0010 returns 0xDEADBEEF.
- if_req and ld_req (read) held high 6 cycles from reset: grants alternate F,L,F,L,F,L; each rvalid routed to the correct port one cycle after its grant.
- Faults: if_addr=0x0040_0002 (misaligned), 0x003F_FFFC (below base), 0x0040_0200 (beyond 128 words):
  - each granted with mem_en=0;
  - next cycle if_rvalid=1, if_err=1, if_rdata=0.
- Grant fetch, then assert reset=0 in the following cycle: no if_rvalid afterward, all outputs 0 during reset.
- IMEM_BOOT_HOLD_EN defined, if_req=1 continuously:
  - no if_gnt while ld_done=0 across 10 loader writes;
  - pulse ld_done=1: if_gnt=1 on the following cycle.

Source files
------------

// File: rtl/imem_access_arbiter.sv
// imem_access_arbiter: round-robin fetch/loader access to a single-port sync-read IMEM.
// Define IMEM_BOOT_HOLD_EN to add ld_done and hold fetch off until the program is loaded.
module imem_access_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int MEMORY_DEPTH = 128,
  parameter int ADDR_WIDTH = 7,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_req,
  input  logic [DATA_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
`ifdef IMEM_BOOT_HOLD_EN
  input  logic                  ld_done,
`endif
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [DATA_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_gnt,
  output logic                  ld_rvalid,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  output logic                  ld_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  logic                  run, gnt_if, gnt_ld, fault;
  logic                  ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] addr, off;
  logic                  v_q, own_q, err_q, wr_q;
  // ptr_q set means fetch was granted last, so loader wins the next contention
  always_comb begin
    gnt_if = reset & run & if_req & ~(ld_req & ptr_q);
    gnt_ld = reset & ld_req & ~gnt_if;
    addr = gnt_if ? if_addr : ld_addr;
    off = addr - TEXT_BASE;
    fault = (addr < TEXT_BASE) | (off[1:0] != 2'b00) |
            ({2'b00, off[DATA_WIDTH-1:2]} >= DATA_WIDTH'(MEMORY_DEPTH));
    ptr_d = gnt_if ? 1'b1 : gnt_ld ? 1'b0 : ptr_q;
  end
  assign if_gnt = gnt_if;
  assign ld_gnt = gnt_ld;
  assign mem_en = (gnt_if | gnt_ld) & ~fault;
  assign mem_we = gnt_ld & ld_we & ~fault;
  assign mem_addr = mem_en ? off[ADDR_WIDTH+1:2] : '0;
  assign mem_wdata = mem_we ? ld_wdata : '0;
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= 1'b0;
      v_q <= 1'b0;
      own_q <= 1'b0;
      err_q <= 1'b0;
      wr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      v_q <= gnt_if | gnt_ld;
      own_q <= gnt_ld;
      err_q <= fault;
      wr_q <= gnt_ld & ld_we;
    end
  end
  // gating with reset drops a response that was in flight when reset hit
  assign if_rvalid = reset & v_q & ~own_q;
  assign if_err = if_rvalid & err_q;
  assign if_rdata = (if_rvalid & ~err_q) ? mem_rdata : '0;
  assign ld_rvalid = reset & v_q & own_q;
  assign ld_err = ld_rvalid & err_q;
  assign ld_rdata = (ld_rvalid & ~err_q & ~wr_q) ? mem_rdata : '0;
`ifdef IMEM_BOOT_HOLD_EN
  typedef enum logic {BOOT, RUN} state_t;
  state_t state_q, state_d;
  always_ff @(posedge clk) begin
    state_q <= !reset ? BOOT : state_d;
  end
  always_comb begin
    state_d = (state_q == BOOT && ld_done && !gnt_ld) ? RUN : state_q;
  end
  assign run = (state_q == RUN);
`else
  assign run = 1'b1;
`endif
endmodule

// File: tb/tb_imem_access_arbiter.sv
// tb_imem_access_arbiter: random + directed bench with a transaction-level reference model.
module tb_imem_access_arbiter;
  localparam logic [31:0] BASE = 32'h0040_0000;
  logic clk, reset;
  logic if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic ld_req, ld_we, ld_gnt, ld_rvalid, ld_err;
  logic [31:0] ld_addr, ld_wdata, ld_rdata;
  logic mem_en, mem_we;
  logic [6:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
`ifdef IMEM_BOOT_HOLD_EN
  logic ld_done;
`endif
  int checks = 0, errors = 0;
  logic [31:0] mem [128];
  logic [31:0] shd [128];

  imem_access_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
`ifdef IMEM_BOOT_HOLD_EN
    .ld_done(ld_done),
`endif
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata), .ld_err(ld_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: one pending response, a "last granted" flag and a shadow memory.
  bit p_v = 0, p_ld = 0, p_err = 0, last_fetch = 0;
  logic [31:0] p_data = 0;
`ifdef IMEM_BOOT_HOLD_EN
  bit run_m = 0;
`else
  bit run_m = 1;
`endif

  always @(negedge clk) begin
    bit eif, eld, ef, ewe;
    longint off;
    int idx;
    logic [31:0] a;
    if (!reset) begin
      chk("rst if_gnt", if_gnt, 0); chk("rst ld_gnt", ld_gnt, 0);
      chk("rst if_rvalid", if_rvalid, 0); chk("rst ld_rvalid", ld_rvalid, 0);
      chk("rst if_rdata", if_rdata, 0); chk("rst ld_rdata", ld_rdata, 0);
      chk("rst if_err", if_err, 0); chk("rst ld_err", ld_err, 0);
      chk("rst mem_en", mem_en, 0); chk("rst mem_we", mem_we, 0);
      chk("rst mem_addr", 32'(mem_addr), 0); chk("rst mem_wdata", mem_wdata, 0);
      p_v = 0; last_fetch = 0;
`ifdef IMEM_BOOT_HOLD_EN
      run_m = 0;
`endif
    end else begin
      chk("if_rvalid", if_rvalid, p_v && !p_ld);
      chk("ld_rvalid", ld_rvalid, p_v && p_ld);
      chk("if_err", if_err, p_v && !p_ld && p_err);
      chk("ld_err", ld_err, p_v && p_ld && p_err);
      chk("if_rdata", if_rdata, (p_v && !p_ld) ? p_data : 0);
      chk("ld_rdata", ld_rdata, (p_v && p_ld) ? p_data : 0);
      eif = if_req && run_m && !(ld_req && last_fetch);
      eld = ld_req && !eif;
      chk("if_gnt", if_gnt, eif);
      chk("ld_gnt", ld_gnt, eld);
      if (eif || eld) begin
        a = eif ? if_addr : ld_addr;
        off = longint'({32'h0, a}) - longint'({32'h0, BASE});
        ef = off < 0 || off % 4 != 0 || off / 4 >= 128;
        idx = ef ? 0 : int'(off / 4);
        ewe = eld && ld_we && !ef;
        chk("mem_en", mem_en, !ef);
        chk("mem_we", mem_we, ewe);
        if (!ef) chk("mem_addr", 32'(mem_addr), idx);
        if (ewe) chk("mem_wdata", mem_wdata, ld_wdata);
        p_v = 1; p_ld = eld; p_err = ef;
        p_data = (ef || (eld && ld_we)) ? 0 : shd[idx];
        if (ewe) shd[idx] = ld_wdata;
        last_fetch = eif;
      end else begin
        chk("idle mem_en", mem_en, 0);
        chk("idle mem_we", mem_we, 0);
        p_v = 0;
      end
`ifdef IMEM_BOOT_HOLD_EN
      if (ld_done && !eld) run_m = 1;
`endif
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask
  task automatic at_neg();
    @(negedge clk); #1;
  endtask
  task automatic idle();
    if_req = 0; ld_req = 0; ld_we = 0;
  endtask
  task automatic do_reset();
    reset = 0; idle();
`ifdef IMEM_BOOT_HOLD_EN
    ld_done = 0;
`endif
    cyc(); cyc(); reset = 1;
`ifdef IMEM_BOOT_HOLD_EN
    ld_done = 1; cyc(); ld_done = 0;
`endif
  endtask

  initial begin
    logic [31:0] fa [3];
    int r;
    fa[0] = 32'h0040_0002; fa[1] = 32'h003F_FFFC; fa[2] = 32'h0040_0200;
    for (int i = 0; i < 128; i++) begin
      mem[i] = $urandom; shd[i] = mem[i];
    end
    mem[2] = 32'h0050_0293; shd[2] = 32'h0050_0293;
    mem_rdata = 0;
    reset = 0; idle(); if_addr = 0; ld_addr = 0; ld_wdata = 0;
`ifdef IMEM_BOOT_HOLD_EN
    ld_done = 0;
`endif
    cyc();
    if_req = 1; if_addr = BASE;
    at_neg(); chk("lit rst no gnt", if_gnt, 0); chk("lit rst mem_en", mem_en, 0);
    cyc(); if_req = 0; reset = 1;
`ifdef IMEM_BOOT_HOLD_EN
    if_req = 1; if_addr = BASE;
    for (int i = 0; i < 10; i++) begin
      ld_req = 1; ld_we = 1; ld_addr = BASE + 32'(4 * (20 + i)); ld_wdata = $urandom;
      at_neg(); chk("lit boot if_gnt", if_gnt, 0); chk("lit boot ld_gnt", ld_gnt, 1);
      cyc();
    end
    ld_req = 0; ld_we = 0; ld_done = 1;
    at_neg(); chk("lit boot hold", if_gnt, 0);
    cyc(); ld_done = 0;
    at_neg(); chk("lit boot release", if_gnt, 1);
    cyc(); idle(); cyc();
`endif
    do_reset();
    if_req = 1; if_addr = 32'h0040_0008;
    at_neg(); chk("lit f gnt", if_gnt, 1); chk("lit f en", mem_en, 1); chk("lit f addr", 32'(mem_addr), 2);
    cyc(); idle();
    at_neg(); chk("lit f rvalid", if_rvalid, 1); chk("lit f rdata", if_rdata, 32'h0050_0293); chk("lit f err", if_err, 0);
    cyc();
    ld_req = 1; ld_we = 1; ld_addr = 32'h0040_0010; ld_wdata = 32'hDEAD_BEEF;
    at_neg(); chk("lit w gnt", ld_gnt, 1); chk("lit w we", mem_we, 1); chk("lit w addr", 32'(mem_addr), 4);
    cyc(); idle();
    at_neg(); chk("lit w rvalid", ld_rvalid, 1); chk("lit w rdata", ld_rdata, 0); chk("lit w err", ld_err, 0);
    cyc();
    if_req = 1; if_addr = 32'h0040_0010;
    cyc(); idle();
    at_neg(); chk("lit raw rdata", if_rdata, 32'hDEAD_BEEF);
    cyc();
    do_reset();
    if_req = 1; ld_req = 1; ld_we = 0; if_addr = BASE; ld_addr = BASE + 4;
    for (int i = 0; i < 6; i++) begin
      at_neg();
      chk("lit rr if_gnt", if_gnt, (i % 2) == 0);
      chk("lit rr ld_gnt", ld_gnt, (i % 2) == 1);
      if (i > 0) chk("lit rr if_rvalid", if_rvalid, (i % 2) == 1);
      if (i > 0) chk("lit rr ld_rvalid", ld_rvalid, (i % 2) == 0);
      cyc();
    end
    idle(); cyc();
    for (int i = 0; i < 3; i++) begin
      if_req = 1; if_addr = fa[i];
      at_neg(); chk("lit flt gnt", if_gnt, 1); chk("lit flt en", mem_en, 0);
      cyc(); idle();
      at_neg(); chk("lit flt rvalid", if_rvalid, 1); chk("lit flt err", if_err, 1); chk("lit flt rdata", if_rdata, 0);
      cyc();
    end
    if_req = 1; if_addr = BASE + 8;
    at_neg(); chk("lit mid gnt", if_gnt, 1);
    cyc(); idle(); reset = 0;
    at_neg(); chk("lit mid rvalid rst", if_rvalid, 0);
    cyc(); reset = 1;
    at_neg(); chk("lit mid rvalid after", if_rvalid, 0);
    cyc();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 199) != 0);
      if_req = ($urandom_range(0, 3) != 0);
      ld_req = ($urandom_range(0, 2) != 0);
      ld_we = $urandom_range(0, 1);
      ld_wdata = $urandom;
`ifdef IMEM_BOOT_HOLD_EN
      ld_done = ($urandom_range(0, 15) == 0);
`endif
      for (int k = 0; k < 2; k++) begin
        r = $urandom_range(0, 11);
        case (r)
          0: fa[k] = BASE + 32'($urandom_range(0, 127) * 4 + $urandom_range(1, 3));
          1: fa[k] = 32'($urandom_range(0, 32'h003F_FFFF));
          2: fa[k] = BASE + 32'((128 + $urandom_range(0, 1000)) * 4);
          3: fa[k] = $urandom;
          4: fa[k] = BASE + 32'd508;
          default: fa[k] = BASE + 32'($urandom_range(0, 127) * 4);
        endcase
      end
      if_addr = fa[0]; ld_addr = fa[1];
      cyc();
    end
    idle(); reset = 1; cyc(); cyc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
